// File: rtl/game_judge_if.sv
// Board-in / verdict-out bundle between the board store and the game judge.
interface game_judge_if;
    logic       move_done;
    logic [1:0] pos1;
    logic [1:0] pos2;
    logic [1:0] pos3;
    logic [1:0] pos4;
    logic [1:0] pos5;
    logic [1:0] pos6;
    logic [1:0] pos7;
    logic [1:0] pos8;
    logic [1:0] pos9;
    logic       busy;
    logic       result_valid;
    logic [1:0] winner;
    logic [2:0] win_line;
    logic       draw;
    logic       game_over;
    logic       bad_cell;
    logic [2:0] led_out1;
    logic [2:0] led_out2;

    modport master (
        output move_done, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        input  busy, result_valid, winner, win_line, draw, game_over, bad_cell,
               led_out1, led_out2
    );

    modport slave (
        input  move_done, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        output busy, result_valid, winner, win_line, draw, game_over, bad_cell,
               led_out1, led_out2
    );
endinterface

// File: rtl/game_judge.sv
// Tic-tac-toe referee: snapshots the board after each move, scans the eight
// lines one per cycle and reports win/draw/turn status plus player LEDs.
module game_judge #(
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    game_judge_if.slave bus
);
    localparam int            CW         = $clog2(BLINK_CYCLES + 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);
    localparam logic [CW-1:0] BLINK_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2,
        OVER   = 2'd3
    } state_t;

    // Three 4-bit cell indices (0-based) of each line, first cell in the MSBs.
    function automatic logic [11:0] line_cells(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = {4'd0, 4'd1, 4'd2};
            3'd1:    c = {4'd3, 4'd4, 4'd5};
            3'd2:    c = {4'd6, 4'd7, 4'd8};
            3'd3:    c = {4'd0, 4'd3, 4'd6};
            3'd4:    c = {4'd1, 4'd4, 4'd7};
            3'd5:    c = {4'd2, 4'd5, 4'd8};
            3'd6:    c = {4'd0, 4'd4, 4'd8};
            3'd7:    c = {4'd2, 4'd4, 4'd6};
            default: c = {4'd0, 4'd1, 4'd2};
        endcase
        return c;
    endfunction

    function automatic logic [1:0] count_code(input logic [1:0] a, input logic [1:0] b,
                                              input logic [1:0] c, input logic [1:0] code);
        return {1'b0, a == code} + {1'b0, b == code} + {1'b0, c == code};
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic [1:0]    pos_s [9];
    logic [1:0]    snap_r [9];
    logic [2:0]    line_idx_r;
    logic          hit_r;
    logic [2:0]    hit_line_r;
    logic [1:0]    hit_owner_r;
    logic [3:0]    n1_r;
    logic [3:0]    n2_r;
    logic          pending_r;
    logic [CW-1:0] blink_cnt_r;
    logic          phase_r;

    logic          busy_r;
    logic          result_valid_r;
    logic [1:0]    winner_r;
    logic [2:0]    win_line_r;
    logic          draw_r;
    logic          game_over_r;
    logic          bad_cell_r;
    logic [2:0]    led1_r;
    logic [2:0]    led2_r;

    logic          any_bad_s;
    logic [11:0]   cell_idx_s;
    logic [1:0]    ca_s;
    logic [1:0]    cb_s;
    logic [1:0]    cc_s;
    logic          line_hit_s;
    logic [4:0]    sum_s;
    logic          draw_now_s;
    logic          finish_s;
    logic          rescan_s;
    logic          take_snap_s;
    logic [2:0]    led1_s;
    logic [2:0]    led2_s;

    // Gather the input cells and flag any illegal code.
    always_comb begin
        pos_s[0] = bus.pos1;
        pos_s[1] = bus.pos2;
        pos_s[2] = bus.pos3;
        pos_s[3] = bus.pos4;
        pos_s[4] = bus.pos5;
        pos_s[5] = bus.pos6;
        pos_s[6] = bus.pos7;
        pos_s[7] = bus.pos8;
        pos_s[8] = bus.pos9;
        any_bad_s = 1'b0;
        for (int i = 0; i < 9; i++) begin
            any_bad_s = any_bad_s | (pos_s[i] == 2'b11);
        end
    end

    // Evaluate the current line and the verdict available in REPORT.
    always_comb begin
        cell_idx_s = line_cells(line_idx_r);
        ca_s       = snap_r[cell_idx_s[11:8]];
        cb_s       = snap_r[cell_idx_s[7:4]];
        cc_s       = snap_r[cell_idx_s[3:0]];
        line_hit_s = (ca_s != 2'b00) && (ca_s == cb_s) && (cb_s == cc_s);
        sum_s      = {1'b0, n1_r} + {1'b0, n2_r};
        draw_now_s = !hit_r && (sum_s == 5'd9);
        finish_s   = hit_r || draw_now_s;
        rescan_s   = pending_r || bus.move_done;
    end

    // LED fields to publish when a result without blinking is reported.
    always_comb begin
        led1_s = 3'b000;
        led2_s = 3'b000;
        if (hit_r) begin
            led1_s = (hit_owner_r == 2'b01) ? 3'b111 : 3'b000;
            led2_s = (hit_owner_r == 2'b10) ? 3'b111 : 3'b000;
        end else if (draw_now_s) begin
            led1_s = 3'b010;
            led2_s = 3'b010;
        end else if (bad_cell_r) begin
            led1_s = 3'b100;
            led2_s = 3'b100;
        end else if (n1_r == n2_r) begin
            led1_s = 3'b001;
            led2_s = 3'b000;
        end else begin
            led1_s = 3'b000;
            led2_s = 3'b001;
        end
    end

    // Next-state logic; a snapshot is taken on every entry into SCAN.
    always_comb begin
        state_s     = state_r;
        take_snap_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.move_done) begin
                    state_s     = SCAN;
                    take_snap_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (line_idx_r == 3'd7) begin
                    state_s = REPORT;
                end else begin
                    state_s = SCAN;
                end
            end
            REPORT: begin
                if (finish_s) begin
                    state_s = OVER;
                end else if (rescan_s) begin
                    state_s     = SCAN;
                    take_snap_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            OVER:    state_s = OVER;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Snapshot, line scan, first-hit latch, piece counts and rescan request.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                snap_r[i] <= 2'b00;
            end
            line_idx_r  <= 3'd0;
            hit_r       <= 1'b0;
            hit_line_r  <= 3'd0;
            hit_owner_r <= 2'b00;
            n1_r        <= 4'd0;
            n2_r        <= 4'd0;
            pending_r   <= 1'b0;
        end else if (take_snap_s) begin
            for (int i = 0; i < 9; i++) begin
                snap_r[i] <= (pos_s[i] == 2'b11) ? 2'b00 : pos_s[i];
            end
            line_idx_r  <= 3'd0;
            hit_r       <= 1'b0;
            hit_line_r  <= 3'd0;
            hit_owner_r <= 2'b00;
            n1_r        <= 4'd0;
            n2_r        <= 4'd0;
            pending_r   <= 1'b0;
        end else if (state_r == SCAN) begin
            line_idx_r <= line_idx_r + 3'd1;
            if (line_hit_s && !hit_r) begin
                hit_r       <= 1'b1;
                hit_line_r  <= line_idx_r;
                hit_owner_r <= ca_s;
            end
            // The three rows cover every cell exactly once.
            if (line_idx_r < 3'd3) begin
                n1_r <= n1_r + {2'b00, count_code(ca_s, cb_s, cc_s, 2'b01)};
                n2_r <= n2_r + {2'b00, count_code(ca_s, cb_s, cc_s, 2'b10)};
            end
            if (bus.move_done) begin
                pending_r <= 1'b1;
            end
        end else if (state_r == REPORT) begin
            pending_r <= 1'b0;
        end
    end

    // Registered status outputs, LED fields and winner blink timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            winner_r       <= 2'b00;
            win_line_r     <= 3'd0;
            draw_r         <= 1'b0;
            game_over_r    <= 1'b0;
            bad_cell_r     <= 1'b0;
            led1_r         <= 3'b001;
            led2_r         <= 3'b000;
            blink_cnt_r    <= '0;
            phase_r        <= 1'b0;
        end else begin
            busy_r         <= (state_s == SCAN) || (state_s == REPORT);
            result_valid_r <= (state_r == REPORT);
            if (take_snap_s) begin
                bad_cell_r <= any_bad_s;
            end
            if (state_r == REPORT) begin
                winner_r    <= hit_r ? hit_owner_r : 2'b00;
                win_line_r  <= hit_r ? hit_line_r : 3'd0;
                draw_r      <= draw_now_s;
                game_over_r <= finish_s;
                led1_r      <= led1_s;
                led2_r      <= led2_s;
                blink_cnt_r <= '0;
                phase_r     <= 1'b0;
            end else if ((state_r == OVER) && (winner_r != 2'b00)) begin
                if (blink_cnt_r == BLINK_LAST) begin
                    blink_cnt_r <= '0;
                    phase_r     <= ~phase_r;
                    if (winner_r == 2'b01) begin
                        led1_r <= phase_r ? 3'b111 : 3'b000;
                    end else begin
                        led2_r <= phase_r ? 3'b111 : 3'b000;
                    end
                end else begin
                    blink_cnt_r <= blink_cnt_r + BLINK_ONE;
                end
            end
        end
    end

    assign bus.busy         = busy_r;
    assign bus.result_valid = result_valid_r;
    assign bus.winner       = winner_r;
    assign bus.win_line     = win_line_r;
    assign bus.draw         = draw_r;
    assign bus.game_over    = game_over_r;
    assign bus.bad_cell     = bad_cell_r;
    assign bus.led_out1     = led1_r;
    assign bus.led_out2     = led2_r;
endmodule

// File: tb/tb_game_judge.sv
// Self-checking bench for game_judge: latency/event model checked every cycle,
// directed scenarios with literal expectations, then randomized moves.
module tb_game_judge;
    localparam int BLINK = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       md;
    logic [1:0] brd [9];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    game_judge_if bus();

    assign bus.move_done = md;
    assign bus.pos1 = brd[0];
    assign bus.pos2 = brd[1];
    assign bus.pos3 = brd[2];
    assign bus.pos4 = brd[3];
    assign bus.pos5 = brd[4];
    assign bus.pos6 = brd[5];
    assign bus.pos7 = brd[6];
    assign bus.pos8 = brd[7];
    assign bus.pos9 = brd[8];

    game_judge #(.BLINK_CYCLES(BLINK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int m_snap [9];
    bit m_active, m_pending, m_over;
    int m_start, m_blink_start, cyc;
    int e_busy, e_rv, e_win, e_line, e_draw, e_go, e_bad, e_led1, e_led2;

    task automatic m_start_scan();
        e_bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (brd[i] == 2'b11) begin
                e_bad      = 1;
                m_snap[i]  = 0;
            end else begin
                m_snap[i]  = int'(brd[i]);
            end
        end
        m_active  = 1;
        m_pending = 0;
        m_start   = cyc;
    endtask

    task automatic m_report();
        int w, wl, n1, n2, a, b, c;
        w = 0; wl = 0; n1 = 0; n2 = 0;
        for (int l = 0; l < 8; l++) begin
            a = m_snap[lines[l][0]];
            b = m_snap[lines[l][1]];
            c = m_snap[lines[l][2]];
            if (w == 0 && a != 0 && a == b && b == c) begin
                w  = a;
                wl = l;
            end
        end
        for (int i = 0; i < 9; i++) begin
            if (m_snap[i] == 1) n1++;
            if (m_snap[i] == 2) n2++;
        end
        e_rv   = 1;
        e_win  = w;
        e_line = (w != 0) ? wl : 0;
        e_draw = (w == 0 && n1 + n2 == 9) ? 1 : 0;
        e_go   = (w != 0 || e_draw == 1) ? 1 : 0;
        if (w != 0) begin
            e_led1 = (w == 1) ? 7 : 0;
            e_led2 = (w == 2) ? 7 : 0;
        end else if (e_draw == 1) begin
            e_led1 = 2; e_led2 = 2;
        end else if (e_bad == 1) begin
            e_led1 = 4; e_led2 = 4;
        end else if (n1 == n2) begin
            e_led1 = 1; e_led2 = 0;
        end else begin
            e_led1 = 0; e_led2 = 1;
        end
    endtask

    // Model advance at each rising edge, then compare all outputs 1 time unit later.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_active = 0; m_pending = 0; m_over = 0;
                e_busy = 0; e_rv = 0; e_win = 0; e_line = 0; e_draw = 0;
                e_go = 0; e_bad = 0; e_led1 = 1; e_led2 = 0;
            end else begin
                e_rv = 0;
                if (m_active && cyc == m_start + 9) begin
                    m_report();
                    if (e_go == 1) begin
                        m_over = 1; m_active = 0; m_pending = 0;
                        m_blink_start = cyc;
                    end else if (m_pending || md) begin
                        m_start_scan();
                    end else begin
                        m_active = 0;
                    end
                end else if (m_active) begin
                    if (md) m_pending = 1;
                end else if (!m_over && md) begin
                    m_start_scan();
                end
                if (m_over && e_win != 0) begin
                    if ((((cyc - m_blink_start) / BLINK) % 2) == 0) begin
                        if (e_win == 1) e_led1 = 7; else e_led2 = 7;
                    end else begin
                        if (e_win == 1) e_led1 = 0; else e_led2 = 0;
                    end
                end
                e_busy = m_active ? 1 : 0;
            end
            #1;
            check("busy",         int'(bus.busy),         e_busy);
            check("result_valid", int'(bus.result_valid), e_rv);
            check("winner",       int'(bus.winner),       e_win);
            check("win_line",     int'(bus.win_line),     e_line);
            check("draw",         int'(bus.draw),         e_draw);
            check("game_over",    int'(bus.game_over),    e_go);
            check("bad_cell",     int'(bus.bad_cell),     e_bad);
            check("led_out1",     int'(bus.led_out1),     e_led1);
            check("led_out2",     int'(bus.led_out2),     e_led2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        md    = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic move(input int c1, input int c2, input int c3, input int c4, input int c5,
                        input int c6, input int c7, input int c8, input int c9);
        @(negedge clk);
        brd[0] = c1[1:0]; brd[1] = c2[1:0]; brd[2] = c3[1:0];
        brd[3] = c4[1:0]; brd[4] = c5[1:0]; brd[5] = c6[1:0];
        brd[6] = c7[1:0]; brd[7] = c8[1:0]; brd[8] = c9[1:0];
        md = 1'b1;
        @(negedge clk);
        md = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.result_valid) break;
        end
        if (!bus.result_valid) begin
            check("result_timeout", 0, 1);
        end
    endtask

    task automatic no_result(input int n, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.result_valid) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        int lat, lat2, r;
        reset = 1'b1;
        md    = 1'b0;
        for (int i = 0; i < 9; i++) brd[i] = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset then idle
        no_result(20, "idle_no_result");
        check("idle_led1", int'(bus.led_out1), 1);
        check("idle_led2", int'(bus.led_out2), 0);
        check("idle_busy", int'(bus.busy), 0);

        // Player1 top row, blink and ignored later move
        move(1, 1, 1, 2, 2, 0, 0, 0, 0);
        wait_result(lat);
        check("row_latency", lat, 9);
        check("row_winner", int'(bus.winner), 1);
        check("row_line", int'(bus.win_line), 0);
        check("row_over", int'(bus.game_over), 1);
        check("row_led1_0", int'(bus.led_out1), 7);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            check("row_blink", int'(bus.led_out1), (((i / 2) % 2) == 1) ? 0 : 7);
            check("row_led2", int'(bus.led_out2), 0);
        end
        move(2, 2, 0, 0, 0, 0, 0, 0, 0);
        no_result(12, "over_ignores_move");
        check("over_winner_held", int'(bus.winner), 1);
        do_reset();

        // Player2 anti-diagonal
        move(1, 1, 2, 1, 2, 0, 2, 0, 0);
        wait_result(lat);
        check("diag_winner", int'(bus.winner), 2);
        check("diag_line", int'(bus.win_line), 7);
        check("diag_draw", int'(bus.draw), 0);
        check("diag_led2", int'(bus.led_out2), 7);
        do_reset();

        // Full board draw
        move(1, 2, 1, 1, 2, 2, 2, 1, 1);
        wait_result(lat);
        check("draw_winner", int'(bus.winner), 0);
        check("draw_flag", int'(bus.draw), 1);
        check("draw_led1", int'(bus.led_out1), 2);
        check("draw_led2", int'(bus.led_out2), 2);
        do_reset();

        // Single piece: player2 to move, back to IDLE
        move(0, 0, 0, 0, 1, 0, 0, 0, 0);
        wait_result(lat);
        check("single_draw", int'(bus.draw), 0);
        check("single_led1", int'(bus.led_out1), 0);
        check("single_led2", int'(bus.led_out2), 1);
        @(posedge clk);
        #1;
        check("single_idle_busy", int'(bus.busy), 0);
        do_reset();

        // Second move 3 cycles into a scan triggers a rescan
        move(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        move(1, 0, 0, 0, 2, 0, 0, 0, 0);
        wait_result(lat);
        check("rescan_first_lat", lat, 6);
        check("rescan_first_led2", int'(bus.led_out2), 1);
        wait_result(lat2);
        check("rescan_gap", lat2, 9);
        check("rescan_second_led1", int'(bus.led_out1), 1);
        check("rescan_second_led2", int'(bus.led_out2), 0);
        do_reset();

        // Illegal code on cell 6
        move(0, 0, 0, 0, 0, 3, 0, 0, 0);
        wait_result(lat);
        check("bad_flag", int'(bus.bad_cell), 1);
        check("bad_led1", int'(bus.led_out1), 4);
        check("bad_led2", int'(bus.led_out2), 4);
        do_reset();

        // Reset mid-scan
        move(1, 1, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        no_result(15, "abort_no_result");
        check("abort_led1", int'(bus.led_out1), 1);
        check("abort_winner", int'(bus.winner), 0);
        check("abort_busy", int'(bus.busy), 0);

        // Randomized play
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            md    = 1'b0;
            reset = 1'b0;
            r = int'($urandom_range(0, 99));
            if (r < 2 || (m_over && r < 15)) begin
                reset = 1'b1;
            end else if (r < 20) begin
                for (int i = 0; i < 9; i++) begin
                    r = int'($urandom_range(0, 19));
                    brd[i] = (r < 1) ? 2'b11 : (r < 8) ? 2'b00 : (r < 14) ? 2'b01 : 2'b10;
                end
                md = 1'b1;
            end
        end
        @(negedge clk);
        md = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
